// File: rtl/flex_updown_counter.sv
// flex_updown_counter: N-bit up/down counter with programmable rollover value,
// synchronous clear and parallel load, wrap or saturate mode, registered
// terminal-count flags and a one-cycle wrap pulse.
//
// Ports:
//   CLK            rising-edge clock
//   n_rst          asynchronous active-low reset
//   clear          synchronous clear to 0 (highest priority)
//   load           synchronous parallel load of load_val
//   load_val       value captured on load
//   count_enable   advance one step this cycle
//   dir            1 = count up, 0 = count down
//   saturate       1 = hold at terminal value, 0 = wrap
//   rollover_val   terminal count; 0 disables counting
//   count_out      registered count
//   rollover_flag  high while count_out == rollover_val (rollover_val != 0)
//   underflow_flag high while count_out == 1 and counting down
//   wrap_pulse     one-cycle pulse following each wrap transition
module flex_updown_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    dir,
    input  logic                    saturate,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    underflow_flag,
    output logic                    wrap_pulse
);
    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] next_count;
    logic                    step;
    logic                    up_term;
    logic                    dn_term;
    logic                    wrap;

    // Terminal tests come before any increment/decrement, so the arithmetic
    // never overflows even when a load placed the count above rollover_val.
    always_comb begin
        step       = count_enable && (rollover_val != '0);
        up_term    = count_out >= rollover_val;
        dn_term    = count_out <= ONE;
        wrap       = !clear && !load && step && !saturate && (dir ? up_term : dn_term);
        next_count = clear ? '0 :
                     load  ? load_val :
                     !step ? count_out :
                     dir   ? (up_term ? (saturate ? count_out : ONE) : count_out + ONE) :
                             (dn_term ? (saturate ? count_out : rollover_val) : count_out - ONE);
    end

    // Flags are derived from the next count so they line up with count_out.
    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            wrap_pulse     <= 1'b0;
        end else begin
            count_out      <= next_count;
            rollover_flag  <= (rollover_val != '0) && (next_count == rollover_val);
            underflow_flag <= !dir && (next_count == ONE);
            wrap_pulse     <= wrap;
        end
    end
endmodule

// File: tb/tb_flex_updown_counter.sv
// tb_flex_updown_counter: directed test-plan steps plus randomized traffic
// checked against a behavioural model of the counter rules.
module tb_flex_updown_counter;
    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         CLK = 1'b0;
    logic         n_rst = 1'b0;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         count_enable = 1'b0;
    logic         dir = 1'b1;
    logic         saturate = 1'b0;
    logic [W-1:0] rollover_val = '0;
    logic [W-1:0] count_out;
    logic         rollover_flag;
    logic         underflow_flag;
    logic         wrap_pulse;

    int checks = 0;
    int failures = 0;
    int m_cnt = 0;
    int m_rf = 0;
    int m_uf = 0;
    int m_wp = 0;

    int up_seq[7] = '{1, 2, 3, 4, 5, 1, 2};
    int up_rf[7]  = '{0, 0, 0, 0, 1, 0, 0};
    int up_wp[7]  = '{0, 0, 0, 0, 0, 1, 0};
    int dn_seq[4] = '{2, 1, 6, 5};
    int dn_uf[4]  = '{0, 1, 0, 0};
    int dn_wp[4]  = '{0, 0, 1, 0};

    flex_updown_counter #(.NUM_CNT_BITS(W)) dut (
        .CLK(CLK),
        .n_rst(n_rst),
        .clear(clear),
        .load(load),
        .load_val(load_val),
        .count_enable(count_enable),
        .dir(dir),
        .saturate(saturate),
        .rollover_val(rollover_val),
        .count_out(count_out),
        .rollover_flag(rollover_flag),
        .underflow_flag(underflow_flag),
        .wrap_pulse(wrap_pulse)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp))
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_count"}, 32'(count_out), m_cnt);
        chk({tag, "_rflag"}, 32'(rollover_flag), m_rf);
        chk({tag, "_uflag"}, 32'(underflow_flag), m_uf);
        chk({tag, "_wrap"}, 32'(wrap_pulse), m_wp);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_rf = 0;
        m_uf = 0;
        m_wp = 0;
    endtask

    // Spec rules applied directly to the sampled inputs with plain integers.
    task automatic model_step();
        int rv;
        rv = int'(rollover_val);
        m_wp = 0;
        if (clear) m_cnt = 0;
        else if (load) m_cnt = int'(load_val);
        else if (count_enable && rv != 0) begin
            if (dir) begin
                if (m_cnt < rv) m_cnt = m_cnt + 1;
                else if (!saturate) begin m_cnt = 1; m_wp = 1; end
            end else begin
                if (m_cnt > 1) m_cnt = m_cnt - 1;
                else if (!saturate) begin m_cnt = rv; m_wp = 1; end
            end
        end
        m_rf = (rv != 0 && m_cnt == rv) ? 1 : 0;
        m_uf = (m_cnt == 1 && !dir) ? 1 : 0;
    endtask

    task automatic cycle(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        chk_all(tag);
    endtask

    task automatic set_in(input logic c, input logic l, input int lv, input logic en,
                          input logic d, input logic s, input int rv);
        clear = c;
        load = l;
        load_val = W'(lv);
        count_enable = en;
        dir = d;
        saturate = s;
        rollover_val = W'(rv);
    endtask

    initial begin
        model_reset();
        #12;
        chk_all("reset");
        n_rst = 1'b1;

        set_in(0, 0, 0, 1, 1, 0, 5);
        for (int i = 0; i < 7; i++) begin
            cycle("up");
            chk("up_seq", 32'(count_out), up_seq[i]);
            chk("up_seq_rflag", 32'(rollover_flag), up_rf[i]);
            chk("up_seq_wrap", 32'(wrap_pulse), up_wp[i]);
        end

        set_in(0, 1, 3, 0, 0, 0, 6);
        cycle("dn_load");
        chk("dn_load_val", 32'(count_out), 3);
        set_in(0, 0, 0, 1, 0, 0, 6);
        for (int i = 0; i < 4; i++) begin
            cycle("dn");
            chk("dn_seq", 32'(count_out), dn_seq[i]);
            chk("dn_seq_uflag", 32'(underflow_flag), dn_uf[i]);
            chk("dn_seq_wrap", 32'(wrap_pulse), dn_wp[i]);
        end

        set_in(1, 0, 0, 0, 1, 1, 4);
        cycle("sat_clr");
        set_in(0, 0, 0, 1, 1, 1, 4);
        for (int i = 0; i < 7; i++) cycle("sat_up");
        chk("sat_up_hold", 32'(count_out), 4);
        chk("sat_up_rflag", 32'(rollover_flag), 1);
        chk("sat_up_nowrap", 32'(wrap_pulse), 0);
        set_in(0, 1, 2, 0, 0, 1, 4);
        cycle("sat_load");
        set_in(0, 0, 0, 1, 0, 1, 4);
        for (int i = 0; i < 4; i++) cycle("sat_dn");
        chk("sat_dn_hold", 32'(count_out), 1);
        chk("sat_dn_nowrap", 32'(wrap_pulse), 0);

        set_in(0, 1, 7, 0, 1, 0, 10);
        cycle("pri_load7");
        set_in(1, 1, 9, 1, 1, 0, 10);
        cycle("pri_clear");
        chk("pri_clear_wins", 32'(count_out), 0);
        set_in(0, 1, 9, 1, 1, 0, 10);
        cycle("pri_load");
        chk("pri_load_wins", 32'(count_out), 9);

        set_in(0, 1, 12, 0, 1, 0, 5);
        cycle("oor_load");
        chk("oor_load_val", 32'(count_out), 12);
        set_in(0, 0, 0, 1, 1, 0, 5);
        cycle("oor_up");
        chk("oor_wrap_to_1", 32'(count_out), 1);
        chk("oor_wrap_pulse", 32'(wrap_pulse), 1);

        set_in(0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle("rv0");
        chk("rv0_hold", 32'(count_out), 1);

        set_in(1, 0, 0, 0, 1, 0, 5);
        cycle("ar_clr");
        set_in(0, 0, 0, 1, 1, 0, 5);
        for (int i = 0; i < 3; i++) cycle("ar_up");
        chk("ar_pre", 32'(count_out), 3);
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        chk_all("ar_async");
        @(posedge CLK);
        #1;
        chk_all("ar_held");
        n_rst = 1'b1;
        cycle("ar_restart");
        chk("ar_restart_1", 32'(count_out), 1);
        cycle("ar_restart");
        chk("ar_restart_2", 32'(count_out), 2);

        for (int i = 0; i < 400; i++) begin
            clear = ($urandom_range(0, 19) == 0);
            load = ($urandom_range(0, 9) == 0);
            load_val = W'($urandom_range(0, MAXV));
            count_enable = ($urandom_range(0, 3) != 0);
            dir = 1'($urandom_range(0, 1));
            saturate = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0)
                rollover_val = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, MAXV));
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flex_updown_counter.md
# flex_updown_counter

Parametrised successor to the team's flex counter: an N-bit up/down counter with programmable rollover value, synchronous clear and parallel load, and a selectable wrap or saturate mode. Registered terminal-count flags and a one-cycle wrap pulse are produced. It sits in the same datapath slots as the flex counter (bit/byte timers, shift-register framing) and is driven through an extended counter interface with the same clocking-block style.

## Interface
- NUM_CNT_BITS, 4, counter width; legal range 2..32.
- CLK  input  1  rising-edge clock.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear to 0; highest priority.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  NUM_CNT_BITS  value captured on load.
- count_enable  input  1  advance one step this cycle.
- dir  input  1  1 = count up, 0 = count down.
- saturate  input  1  1 = hold at terminal value, 0 = wrap.
- rollover_val  input  NUM_CNT_BITS  terminal count; 0 disables counting.
- count_out  output  NUM_CNT_BITS  registered count.
- rollover_flag  output  1  registered; high while count_out == rollover_val (rollover_val != 0).
- underflow_flag  output  1  registered; high while count_out == 1 and dir == 0.
- wrap_pulse  output  1  registered one-cycle pulse when a wrap transition is taken.

## Operation
- Per-edge priority: clear > load > count_enable > hold.
- clear: count_out <= 0; wrap_pulse <= 0.
- load: count_out <= load_val (any value, including > rollover_val); wrap_pulse <= 0.
- rollover_val == 0: count_enable ignored; count holds; clear/load still act.
- Up step (dir=1, enabled):
  - count < rollover_val: count+1.
  - count >= rollover_val, saturate=0: next = 1; wrap_pulse <= 1.
  - count >= rollover_val, saturate=1: hold.
- Down step (dir=0, enabled):
  - count > 1: count-1, also when count > rollover_val.
  - count is 0 or 1, saturate=0: next = rollover_val; wrap_pulse <= 1.
  - count is 0 or 1, saturate=1: hold.
- Wrap-mode steady cycles: up 1..rollover_val; down rollover_val..1. Value 0 occurs only after reset, clear or load.
- Arithmetic is modulo 2^NUM_CNT_BITS, but a terminal test always precedes any increment or decrement, so no natural overflow or underflow occurs.
- dir, saturate and rollover_val may change on any cycle; they take effect on the next edge with no pipeline.

## Timing
- Reset (n_rst low, asynchronous): count_out = 0, rollover_flag = 0, underflow_flag = 0, wrap_pulse = 0. All outputs are held while n_rst is low.
- Deassertion of n_rst is synchronised externally; the first active edge after release behaves normally.
- Flags are computed from next-state count and the current rollover_val/dir, then registered. They are therefore aligned with count_out in the same cycle, with zero lag.
- If rollover_val or dir changes while count holds, the flags update at the next edge.
- wrap_pulse is high for exactly one cycle after each wrap edge and is low otherwise. It is never asserted in saturate mode.
- Latency: one cycle from input sample to count_out and flag change.
- Reset mid-count: all state is lost immediately and counting resumes from 0.

## Test plan
- Reset then up count: NUM_CNT_BITS=4, rollover_val=5, dir=1, saturate=0, enable held.
  - count_out sequence: 0,1,2,3,4,5,1,2.
  - rollover_flag is high only while count_out=5.
  - wrap_pulse is high in the cycle count_out=1 after 5.
- Down wrap: load 3, dir=0, rollover_val=6, enable held.
  - count_out sequence: 3,2,1,6,5.
  - underflow_flag is high while count_out=1.
  - wrap_pulse is high with the first 6.
- Saturate mode:
  - rollover_val=4, saturate=1, up from 0: count_out sticks at 4 with rollover_flag high and wrap_pulse never asserted.
  - dir=0 from 2: count_out sticks at 1.
- Priority:
  - clear=1, load=1, load_val=9, enable=1 at count 7: next count_out=0.
  - load=1, enable=1: next count_out=9.
- Out-of-range and disable:
  - load 12 with rollover_val=5, up, wrap: next count_out=1 with wrap_pulse.
  - rollover_val=0: count holds over 10 enabled cycles.
- Async reset mid-count: n_rst low between clock edges at count 3.
  - All outputs go to 0 before the next edge.
  - After release, counting restarts 0,1,2.
